// File: rtl/imem_pkg.sv
// Shared constants and address helper for the instruction fetch unit.
package imem_pkg;

  localparam int unsigned INST_W          = 32;
  localparam logic [31:0] NOP_INST_DEF    = 32'h00000013;
  localparam int unsigned FETCH_WIDTH_MIN = 1;
  localparam int unsigned FETCH_WIDTH_MAX = 4;
  localparam int unsigned LATENCY_MIN     = 1;
  localparam int unsigned LATENCY_MAX     = 3;

  // Byte address of fetch slot k, wrapped into a power-of-two memory.
  function automatic logic [31:0] slot_addr(input logic [31:0] pc,
                                            input int unsigned k,
                                            input int unsigned depth);
    return (pc + 32'(4 * k)) & 32'(depth - 1);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO with flush and occupancy count output.
module imem_rsp_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 33,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_eff;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_eff  = pop && (count != '0);
  assign valid    = (count != '0);
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // A push arriving with flush survives as the sole entry.
      rd_ptr <= '0;
      wr_ptr <= push ? PW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push)    wr_ptr <= next_ptr(wr_ptr);
      if (pop_eff) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[flush ? '0 : wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Pipelined big-endian instruction memory with buffered valid/ready fetch.
// IMEM_BOUNDS_CHECK_EN: fault misaligned or out-of-range fetches with NOP fill.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned FETCH_WIDTH = 1,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] NOP_INST    = NOP_INST_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_pc,
  input  logic                          flush,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_pc,
  output logic [INST_W*FETCH_WIDTH-1:0] rsp_inst,
  output logic                          rsp_fault,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_addr,
  input  logic [31:0]                   wr_data
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned IW = INST_W * FETCH_WIDTH;
  localparam int unsigned EW = IW + 33;
  localparam int unsigned CW = $clog2(LATENCY + 2);

  if (FETCH_WIDTH < FETCH_WIDTH_MIN || FETCH_WIDTH > FETCH_WIDTH_MAX ||
      LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_cfg
    $error("imem_fetch_unit: FETCH_WIDTH or LATENCY out of range");
  end

  logic [7:0]    mem [DEPTH_BYTES];
  logic          acc;
  logic [31:0]   slot_a [FETCH_WIDTH];
  logic [IW-1:0] rd_inst;
  logic          rd_fault;
  logic [EW-1:0] rd_entry;
  logic          push;
  logic [EW-1:0] push_data;
  logic [31:0]   inflight;
  logic [EW-1:0] head;
  logic          fifo_valid;
  logic [CW-1:0] fifo_count;
  logic          unused_bits;

  assign acc       = req_valid && req_ready;
  assign req_ready = (32'(fifo_count) + inflight) < 32'(LATENCY + 1);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_addr[AW-1:2], 2'd0}] <= wr_data[31:24];
      mem[{wr_addr[AW-1:2], 2'd1}] <= wr_data[23:16];
      mem[{wr_addr[AW-1:2], 2'd2}] <= wr_data[15:8];
      mem[{wr_addr[AW-1:2], 2'd3}] <= wr_data[7:0];
    end
  end

  always_comb begin
    rd_inst = '0;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      slot_a[k] = slot_addr(req_pc, k, DEPTH_BYTES);
      // Byte-wise gather so misaligned and wrapping fetches need no alignment logic.
      for (int unsigned j = 0; j < 4; j++)
        rd_inst[INST_W*k + 8*(3-j) +: 8] = mem[slot_a[k][AW-1:0] + AW'(j)];
    end
`ifdef IMEM_BOUNDS_CHECK_EN
    rd_fault = (req_pc[1:0] != 2'b00);
    for (int unsigned k = 0; k < FETCH_WIDTH; k++)
      if ({1'b0, req_pc} + 33'(4*k + 3) >= 33'(DEPTH_BYTES)) rd_fault = 1'b1;
    if (rd_fault) rd_inst = {FETCH_WIDTH{NOP_INST}};
`else
    rd_fault = 1'b0;
`endif
    rd_entry = {req_pc, rd_fault, rd_inst};
  end

  if (LATENCY == 1) begin : g_lat1
    assign push      = acc;
    assign push_data = rd_entry;
    assign inflight  = '0;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv;
    logic [EW-1:0]      pd [LATENCY-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pv <= '0;
      end else begin
        // The request accepted alongside a flush is the redirect target and is kept.
        pv[0] <= acc;
        for (int unsigned i = 1; i < LATENCY - 1; i++) pv[i] <= pv[i-1] && !flush;
      end
      pd[0] <= rd_entry;
      for (int unsigned i = 1; i < LATENCY - 1; i++) pd[i] <= pd[i-1];
    end

    assign push      = pv[LATENCY-2] && !flush;
    assign push_data = pd[LATENCY-2];

    always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < LATENCY - 1; i++) inflight += 32'(pv[i]);
    end
  end

  imem_rsp_fifo #(
    .DEPTH (LATENCY + 1),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_valid && rsp_ready),
    .pop_data  (head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign rsp_valid = fifo_valid;
  assign rsp_pc    = fifo_valid ? head[EW-1 -: 32] : '0;
  assign rsp_inst  = fifo_valid ? head[IW-1:0] : '0;
`ifdef IMEM_BOUNDS_CHECK_EN
  assign rsp_fault = fifo_valid && head[IW];
`else
  assign rsp_fault = 1'b0;
`endif

  always_comb begin
    unused_bits = ^{wr_addr[31:AW], wr_addr[1:0]};
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) unused_bits ^= ^slot_a[k][31:AW];
`ifndef IMEM_BOUNDS_CHECK_EN
    unused_bits ^= head[IW];
`endif
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit (DEPTH_BYTES=64, FETCH_WIDTH=2, LATENCY=3).
module tb_imem_fetch_unit;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned FW    = 2;
  localparam int unsigned LAT   = 3;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_pc;
  logic          flush;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_pc;
  logic [63:0]   rsp_inst;
  logic          rsp_fault;
  logic          wr_en;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model [DEPTH];

  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  imem_fetch_unit #(
    .DEPTH_BYTES (DEPTH),
    .FETCH_WIDTH (FW),
    .LATENCY     (LAT),
    .NOP_INST    (NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_pc    (rsp_pc),
    .rsp_inst  (rsp_inst),
    .rsp_fault (rsp_fault),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t expect_rsp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.fault = 1'b0;
    e.inst  = '0;
    for (int k = 0; k < FW; k++)
      for (int j = 0; j < 4; j++)
        e.inst[32*k + 8*(3-j) +: 8] = model[(pc + 32'(4*k + j)) % DEPTH];
`ifdef IMEM_BOUNDS_CHECK_EN
    if (pc[1:0] != 2'b00 || 64'(pc) + 64'(4*(FW-1) + 3) >= 64'(DEPTH)) begin
      e.fault = 1'b1;
      e.inst  = {NOP, NOP};
    end
`endif
    return e;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    for (int j = 0; j < 4; j++) model[((a & ~32'd3) + 32'(j)) % DEPTH] = d[31 - 8*j -: 8];
  endtask

  task automatic issue(input logic [31:0] pc, input bit expected);
    req_valid = 1'b1;
    req_pc    = pc;
    check("issue_ready", req_ready, 1);
    if (expected) exp_q.push_back(expect_rsp(pc));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input string tag);
    exp_t e;
    rsp_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_spurious"}, rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_pc"}, rsp_pc, e.pc);
          check({tag, "_inst"}, rsp_inst, e.inst);
          check({tag, "_fault"}, rsp_fault, e.fault);
        end
      end
      tick();
    end
    check({tag, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          n_acc;
    int          stale;
    logic [31:0] pc;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_pc    = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    tick();
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_pc", rsp_pc, 0);
    check("rst_rsp_inst", rsp_inst, 0);
    check("rst_rsp_fault", rsp_fault, 0);
    rst_n = 1'b1;

    // Byte at address x holds 8'h80|x, then a few named words on top.
    for (int a = 0; a < DEPTH; a += 4)
      mem_write(32'(a), {8'(8'h80 | a), 8'(8'h81 | a), 8'(8'h82 | a), 8'(8'h83 | a)});
    mem_write(32'd8,  32'h00408333);
    mem_write(32'd60, 32'hAAAA0001);
    mem_write(32'd0,  32'hBBBB0002);

    // Latency: accepted at edge 0, visible after edge 2.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_pc    = 32'd8;
    check("lat_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("lat_c1_valid", rsp_valid, 0);
    tick();
    check("lat_c2_valid", rsp_valid, 0);
    tick();
    check("lat_c3_valid", rsp_valid, 1);
    check("lat_pc", rsp_pc, 32'd8);
    check("lat_inst", rsp_inst, 64'h8C8D8E8F_00408333);
    check("lat_fault", rsp_fault, 0);
    tick();
    check("lat_popped", rsp_valid, 0);

    // Wrap across the top of memory.
    issue(32'd60, 1'b0);
    for (int c = 0; c < 6 && !rsp_valid; c++) tick();
    check("wrap_valid", rsp_valid, 1);
    check("wrap_pc", rsp_pc, 32'd60);
`ifdef IMEM_BOUNDS_CHECK_EN
    check("wrap_inst", rsp_inst, {NOP, NOP});
    check("wrap_fault", rsp_fault, 1);
`else
    check("wrap_inst", rsp_inst, 64'hBBBB0002_AAAA0001);
    check("wrap_fault", rsp_fault, 0);
`endif
    tick();

    // Misaligned fetch.
    issue(32'd1, 1'b1);
    drain(8, "misalign");

    // Backpressure: only LATENCY+1 requests fit.
    rsp_ready = 1'b0;
    pc        = '0;
    n_acc     = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_pc = pc;
      if (req_ready) begin
        exp_q.push_back(expect_rsp(pc));
        n_acc++;
        pc += 32'd4;
      end
      tick();
    end
    req_valid = 1'b0;
    check("bp_accepted", n_acc, 4);
    check("bp_ready_low", req_ready, 0);
    check("bp_hold_valid", rsp_valid, 1);
    check("bp_hold_pc", rsp_pc, 32'd0);
    check("bp_hold_inst", rsp_inst, 64'h84858687_BBBB0002);
    drain(12, "bp");

    // Flush with in-flight requests; the same-cycle request is kept.
    rsp_ready = 1'b1;
    issue(32'd0, 1'b0);
    issue(32'd4, 1'b0);
    req_valid = 1'b1;
    req_pc    = 32'd40;
    flush     = 1'b1;
    check("flush_ready", req_ready, 1);
    exp_q.push_back(expect_rsp(32'd40));
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_rsp_valid", rsp_valid, 0);
    drain(10, "flush");

    // Read-before-write at the same edge, new data one cycle later.
    wr_en     = 1'b1;
    wr_addr   = 32'h11;
    wr_data   = 32'hDEADBEEF;
    req_valid = 1'b1;
    req_pc    = 32'd16;
    exp_q.push_back(expect_rsp(32'd16));
    tick();
    wr_en = 1'b0;
    for (int j = 0; j < 4; j++) model[16 + j] = wr_data[31 - 8*j -: 8];
    check("rbw_ready", req_ready, 1);
    exp_q.push_back(expect_rsp(32'd16));
    tick();
    req_valid = 1'b0;
    drain(10, "rbw");

    // Reset with two requests in flight.
    rsp_ready = 1'b0;
    issue(32'd0, 1'b0);
    issue(32'd4, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_rsp_valid", rsp_valid, 0);
    check("rst2_req_ready", req_ready, 1);
    check("rst2_rsp_pc", rsp_pc, 0);
    rsp_ready = 1'b1;
    stale     = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) stale++;
      tick();
    end
    check("rst2_no_stale", stale, 0);
    issue(32'd20, 1'b1);
    drain(8, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
Parametrised, pipelined successor to the flat combinational instruction memory. Byte-addressed, big-endian program store: the byte at the lowest address is the MSB of the instruction. Returns FETCH_WIDTH consecutive instructions per request over valid/ready handshakes, with configurable read latency, backpressure buffering, branch-redirect flush, and a runtime write port for program loading. Sits between the PC/branch-redirect logic and the decode/issue stage.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, at least 64
FETCH_WIDTH, 1, instructions per response, 1..4
LATENCY, 1, read pipeline stages from request accept to response, 1..3
NOP_INST, 32'h00000013, filler instruction (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous reset, active-low
req_valid  in  1  fetch request valid
req_ready  out  1  unit can accept a request
req_pc  in  32  byte address of the first instruction
flush  in  1  branch redirect; discards all in-flight and buffered responses
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rsp_pc  out  32  req_pc of the response
rsp_inst  out  32*FETCH_WIDTH  slot k is bits [32k+31:32k], fetched from req_pc+4k
rsp_fault  out  1  fault flag for the response (see Optional Feature)
wr_en  in  1  program-load write strobe
wr_addr  in  32  byte address of the word write; bits [1:0] are ignored
wr_data  in  32  word to store, big-endian byte order

Behaviour:
- Reset (rst_n=0 at an edge): pipeline valid bits cleared, FIFO emptied, occupancy=0. Outputs: rsp_valid=0, rsp_pc=0, rsp_inst=0, rsp_fault=0, req_ready=1 from the first cycle after reset. Memory contents are not cleared.
- Reset mid-operation discards every in-flight request. No response for those requests ever appears.
- Accept: req_valid && req_ready at an edge. Memory is sampled at that edge.
  - Address of slot k = (req_pc + 4k) mod DEPTH_BYTES; fetches wrap around the top of memory.
  - Bytes are gathered individually, so a misaligned pc reads bytes pc..pc+3 as-is.
- Latency: a request accepted at edge t appears at the output from cycle t+LATENCY when the FIFO is empty. Responses leave in order.
- Buffering: response FIFO (imem_rsp_fifo), depth LATENCY+1.
  - req_ready = (fifo_count + inflight) < LATENCY+1.
  - With rsp_ready held at 1, back-to-back throughput is one request per cycle.
- Output: rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
- flush=1 at an edge:
  - Clears all pipeline valid bits and the FIFO.
  - rsp_valid is 0 in the next cycle.
  - A request accepted in the same cycle as flush is kept; it is the redirect target.
  - req_ready is evaluated on the pre-flush counts.
- Write:
  - A word write at wr_addr&~3 takes effect at the edge.
  - A read accepted at the same edge to the same bytes returns the old data (read-before-write).
  - Writes are never blocked, including during flush.
- Occupancy counter: increments on accept, decrements on output handshake. Simultaneous accept and handshake leaves the count unchanged. It never exceeds LATENCY+1.

Optional Feature:
Macro: IMEM_BOUNDS_CHECK_EN.
- Defined: a request with req_pc[1:0] != 0, or with any slot address (unwrapped req_pc+4k+3) >= DEPTH_BYTES, returns rsp_fault=1 and NOP_INST in every slot. It keeps the normal latency and ordering.
- Undefined: rsp_fault is tied to 0. Addresses wrap and misaligned bytes are returned raw.

Decomposition:
- Package imem_pkg:
  - INST_W=32
  - NOP_INST default
  - FETCH_WIDTH and LATENCY legal-range constants
  - Function computing the slot address with wrap
- Sub-module imem_rsp_fifo: parametrised-depth synchronous FIFO with flush, count output and width 32*FETCH_WIDTH+33 (pc + fault + insts).

Test Plan:
- Load add x6,x1,x4 (32'h00408333) at addr 8; FETCH_WIDTH=1, LATENCY=2, request pc=8 -> rsp_valid in cycle t+2 with rsp_inst=32'h00408333 and rsp_pc=8.
- FETCH_WIDTH=2, DEPTH_BYTES=64, words A at 60 and B at 0, request pc=60 -> slot0=A, slot1=B (wrap). With IMEM_BOUNDS_CHECK_EN -> rsp_fault=1 and both slots 32'h00000013.
- LATENCY=3, rsp_ready=0, issue requests continuously -> exactly 4 accepted, then req_ready=0. Release rsp_ready -> responses for pc 0,4,8,12 come out in order.
- Requests at pc 0 and 4 in flight, then flush together with a request at pc=40 -> only the pc=40 response appears.
- wr_en to addr 16 and a read request at pc 16 in the same cycle -> old word returned; a read one cycle later returns the new word.
- Assert rst_n=0 with 2 requests in flight -> rsp_valid=0 and req_ready=1 after reset; no stale response appears.
